circuit_2: RTL and testbench
============================

# circuit_2

Clocked 4-input, 3-output combinational decoder with registered outputs. Samples four single-bit inputs A, B, C, D, treated as the 4-bit value ABCD with A as the MSB. Produces three flags: odd parity, population count of at least two, and primality of the value. Used as a small classification leaf inside larger logic-lab datapaths.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- A  input  1  value bit 3 (MSB).
- B  input  1  value bit 2.
- C  input  1  value bit 1.
- D  input  1  value bit 0 (LSB).
- Out_1  output  1  odd parity of {A,B,C,D}, registered.
- Out_2  output  1  high when two or more of A..D are 1, registered.
- Out_3  output  1  high when ABCD is prime (2,3,5,7,11,13), registered.
- Positional port order: A, B, C, D, Out_1, Out_2, Out_3, then clk, rst. Prefer named connection.

## Operation
- Let v = {A,B,C,D}, an unsigned 4-bit value in the range 0..15.
- Out_1 = A^B^C^D.
- Out_2 = 1 when popcount(v) >= 2, i.e. for v in {3,5,6,7,9,10,11,12,13,14,15}.
- Out_3 = PRIME_MASK[v], where PRIME_MASK = 16'h28AC. 0 and 1 are not prime.
- All three outputs come from a single output register bank, updated every cycle. There is no enable and no handshake.
- Inputs are sampled as-is, with no synchronizer. Inputs must be synchronous to clk.
- X or Z on any input must not be masked. X propagates to the affected outputs.

## Timing
- Reset: while rst=1 at a rising edge, Out_1, Out_2 and Out_3 become 0 on that edge.
- Reset takes priority over input sampling.
- Latency: 1 cycle. Inputs present at edge N appear on the outputs after edge N. This is 2 cycles when the input register is enabled (see Configuration).
- Throughput: one new input vector per cycle.
- Reset deasserted at edge N: the outputs reflect the inputs sampled at edge N+1. With the input register, they reflect the edge-N+1 inputs after edge N+2.
- Reset mid-stream: all pipeline registers clear. The output drops to 0 on the next edge.
- Outputs must be glitch-free, i.e. driven directly from flops.

## Configuration
- Macro: CIRCUIT_2_INPUT_REG_EN.
- When defined: A..D are captured in a 4-bit input register before decoding. Latency is 2 cycles, and the input register also resets to 0 synchronously.
- When undefined: decode is directly from the ports. Latency is 1 cycle.

## Structure
- Package circuit_2_pkg holds:
  - PRIME_MASK (16'h28AC).
  - POPCNT_MIN (2).
  - A typedef for the 4-bit value (logic [3:0]).
  - A packed struct for the three flags {parity, multi, prime}.
- Sub-module circuit_2_decode: purely combinational. Takes the 4-bit value in and returns the flag struct.
- The top level holds only the optional input register, the output register and the reset logic.

## Test plan
- Reset: rst=1 for 2 cycles with A..D=1111 -> Out_1/2/3 = 0/0/0 throughout.
- v=0101 (5) -> after 1 cycle, Out_1=0, Out_2=1, Out_3=1.
- v=0110 (6) -> Out_1=0, Out_2=1, Out_3=0. v=0111 (7) -> Out_1=1, Out_2=1, Out_3=1.
- Exhaustive sweep v=0..15, one value per cycle -> each output matches the reference model, delayed by the configured latency. Check the boundaries: v=0 gives 0/0/0, v=1 gives 1/0/0, v=15 gives 0/1/0.
- Assert rst mid-sweep at v=13 -> outputs become 0 on the next edge. Resumption gives correct flags after the latency.
- Rebuild with CIRCUIT_2_INPUT_REG_EN -> same sequences, shifted by one extra cycle.

Source files
------------

// File: rtl/circuit_2_pkg.sv
// rtl/circuit_2_pkg.sv - shared types and constants for the circuit_2 4-bit classifier
package circuit_2_pkg;

   localparam logic [15:0] PRIME_MASK = 16'h28AC;
   localparam int          POPCNT_MIN = 2;

   typedef logic [3:0] value_t;

   typedef struct packed {
      logic parity;
      logic multi;
      logic prime;
   } flags_t;

   function automatic logic [2:0] popcnt4(input value_t v);
      return {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
   endfunction

endpackage

// File: rtl/circuit_2_decode.sv
// rtl/circuit_2_decode.sv - combinational parity / multi-bit / prime classification of a 4-bit value
module circuit_2_decode
   import circuit_2_pkg::*;
(
   input  value_t value,
   output flags_t flags
);

   // Plain operators and indexing keep X on the input visible on the flags.
   always_comb begin
      flags        = '0;
      flags.parity = ^value;
      flags.multi  = (popcnt4(value) >= 3'(POPCNT_MIN));
      flags.prime  = PRIME_MASK[value];
   end

endmodule

// File: rtl/circuit_2.sv
// rtl/circuit_2.sv - registered 4-input classifier; CIRCUIT_2_INPUT_REG_EN adds an input register stage
module circuit_2
   import circuit_2_pkg::*;
(
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic Out_1,
   output logic Out_2,
   output logic Out_3,
   input  logic clk,
   input  logic rst
);

   value_t dec_in;
   flags_t dec_flags;
   flags_t out_q;

`ifdef CIRCUIT_2_INPUT_REG_EN
   value_t in_q;

   always_ff @(posedge clk) begin
      if (rst) in_q <= '0;
      else     in_q <= {A, B, C, D};
   end

   assign dec_in = in_q;
`else
   assign dec_in = {A, B, C, D};
`endif

   circuit_2_decode u_decode (
      .value (dec_in),
      .flags (dec_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= dec_flags;
   end

   assign Out_1 = out_q.parity;
   assign Out_2 = out_q.multi;
   assign Out_3 = out_q.prime;

endmodule

// File: tb/tb_circuit_2.sv
// tb/tb_circuit_2.sv - directed self-checking bench for circuit_2 (either CIRCUIT_2_INPUT_REG_EN build)
module tb_circuit_2;

`ifdef CIRCUIT_2_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic A = 1'b1, B = 1'b1, C = 1'b1, D = 1'b1;
   logic Out_1, Out_2, Out_3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] m_in  = 4'd0;
   logic [2:0] m_out = 3'd0;

   always #5 clk = ~clk;

   circuit_2 dut (
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .Out_1 (Out_1),
      .Out_2 (Out_2),
      .Out_3 (Out_3),
      .clk   (clk),
      .rst   (rst)
   );

   function automatic logic [2:0] ref_flags(input logic [3:0] v);
      int ones;
      ones = 0;
      for (int i = 0; i < 4; i++) if (v[i]) ones++;
      return {ones % 2 == 1, ones >= 2,
              (v == 4'd2 || v == 4'd3 || v == 4'd5 || v == 4'd7 || v == 4'd11 || v == 4'd13)};
   endfunction

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got Out_1/2/3=%b required %b", tag, got, exp);
      end
   endtask

   // One clock: drive at negedge, advance the reference pipeline at posedge, compare at next negedge.
   task automatic cycle(input logic [3:0] v, input logic r, input string tag);
      {A, B, C, D} = v;
      rst = r;
      @(posedge clk);
      if (LAT == 2) begin
         m_out = r ? 3'd0 : ref_flags(m_in);
         m_in  = r ? 4'd0 : v;
      end else begin
         m_out = r ? 3'd0 : ref_flags(v);
      end
      @(negedge clk);
      check(tag, {Out_1, Out_2, Out_3}, m_out);
   endtask

   task automatic hold(input logic [3:0] v, input logic [2:0] exp, input string tag);
      for (int i = 0; i < LAT; i++) cycle(v, 1'b0, "pipe");
      check(tag, {Out_1, Out_2, Out_3}, exp);
   endtask

   initial begin
      @(negedge clk);
      cycle(4'hF, 1'b1, "reset_model");
      check("reset_0", {Out_1, Out_2, Out_3}, 3'b000);
      cycle(4'hF, 1'b1, "reset_model");
      check("reset_1", {Out_1, Out_2, Out_3}, 3'b000);

      hold(4'd5, 3'b011, "v5");
      hold(4'd6, 3'b010, "v6");
      hold(4'd7, 3'b111, "v7");

      for (int v = 0; v < 16; v++) cycle(4'(v), 1'b0, "sweep");
      for (int i = 0; i < LAT; i++) cycle(4'd15, 1'b0, "sweep_flush");

      hold(4'd0,  3'b000, "v0");
      hold(4'd1,  3'b100, "v1");
      hold(4'd15, 3'b010, "v15");

      for (int v = 8; v < 13; v++) cycle(4'(v), 1'b0, "sweep2");
      cycle(4'd13, 1'b1, "mid_reset_model");
      check("mid_reset", {Out_1, Out_2, Out_3}, 3'b000);
      cycle(4'd14, 1'b0, "resume");
      cycle(4'd15, 1'b0, "resume");
      hold(4'd13, 3'b111, "v13_after_reset");
      hold(4'd11, 3'b111, "v11");
      hold(4'd9,  3'b010, "v9");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
